booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
- Sequential signed 32x32 multiplier using radix-4 (bit-pair) Booth recoding.
- Companion to the non-restoring divider in the ALU's MUL/DIV path.
- Writes the 64-bit product as HI in Z[63:32] and LO in Z[31:0], the same Z-register split the divider uses.
- Takes 16 iteration cycles, plus a start/done handshake so the control unit can stall on it.

Parameters:
- WIDTH, 32, operand width; must be even and >= 4.
- ITER, WIDTH/2, number of Booth iterations. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  request pulse; operands are sampled on the edge where start=1 is accepted.
- M  input  WIDTH  multiplicand, two's complement.
- Q  input  WIDTH  multiplier, two's complement.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when the product becomes valid.
- product_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH] (Z high word).
- product_lo  output  WIDTH  product bits [WIDTH-1:0] (Z low word).

Behaviour:
- Reset is synchronous and active-low on clk. When resetn=0 at an edge:
  - state <= IDLE; iteration counter <= 0.
  - busy=0, done=0, product_hi=0, product_lo=0.
  - Reset wins over start in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches M (sign-extended to WIDTH+2 bits).
  - Loads the accumulator A=0, the multiplier register P=Q, and the appended bit q_-1=0. Counter=0.
  - Goes to RUN; busy=1 from the next cycle.
  - start=0 keeps IDLE. Outputs hold their last product.
- RUN, one Booth step per edge:
  - Recode {P[1],P[0],q_-1}:
    - 000 or 111 -> +0
    - 001 or 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101 or 110 -> -M
  - A <= A + selected term, computed in WIDTH+2 bits so that -2*(-2^31) does not overflow.
  - Then arithmetic-shift {A,P,q_-1} right by 2.
  - Counter increments. On the edge completing iteration ITER: go to DONE and register product_hi/product_lo from {A[WIDTH-1:0], P}.
- DONE, one cycle: done=1, busy=0, product valid.
  - start=1 in DONE is accepted exactly as in IDLE, so back-to-back operations are supported. Otherwise go to IDLE.
- Latency: start accepted at edge 0 -> done=1 in the cycle following edge 16.
  - That is 17 edges from acceptance to done cycle.
  - Throughput is one product per 17 cycles.
- start while busy is ignored: no restart and no operand re-sample.
- M and Q may change after acceptance; they are not sampled again.
- Product outputs change only on entering DONE or on reset. They hold indefinitely otherwise.
- Reset mid-RUN aborts immediately. The next start begins a fresh operation with no residue.
- Exact signed result for all inputs, including -2^31 * -2^31 = 2^62. No overflow flag is produced.

Decomposition:
- Package mul_div_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the Booth op enum {B_ZERO, B_PM, B_P2M, B_NM, B_N2M};
  - the localparam for the default width.
  - The divider is to be migrated onto this package later.
- One natural sub-module: booth_recoder. It is combinational, maps the 3-bit group to the op enum, and is unit-testable alone.
- The adder/shift datapath stays in booth_mul_seq.

Test Plan:
- M=38, Q=6 -> after 17 edges: done=1, hi=0x00000000, lo=0x000000E4. busy is high for exactly 16 cycles.
- M=-7 (0xFFFFFFF9), Q=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFDD (-35). Repeat with M=5, Q=-7 for the same result.
- Extremes:
  - M=Q=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
  - M=Q=0x80000000 -> hi=0x40000000, lo=0x00000000.
  - M=0x80000000, Q=0xFFFFFFFF -> hi=0x00000000, lo=0x80000000.
- start pulsed again at cycles 3 and 10 with different operands -> ignored. Original product is delivered at cycle 17, and done is a single pulse.
- resetn=0 at cycle 8 of a run -> next cycle busy=0, done=0, outputs=0. A new start with M=100, Q=25 then yields lo=0x000009C4, hi=0.
- start held high through DONE -> second operation accepted in the DONE cycle. Second done follows 17 cycles after the first, and the first product stays visible until then.

Source files
------------

// File: rtl/mul_div_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_pkg
//   Shared types and constants for the ALU MUL/DIV path.
//   - mul_state_e : sequencing states of the iterative multiplier
//   - booth_op_e  : radix-4 Booth partial-product selection
//   - MUL_WIDTH   : default operand width
//   - booth_op_name : readable name of a Booth op, handy in debug output
// The divider is expected to move onto this package later, so keep the
// contents generic to the MUL/DIV path rather than multiplier-specific.
// ---------------------------------------------------------------------------
package mul_div_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Partial-product term added to the accumulator each Booth step.
  typedef enum logic [2:0] {
    B_ZERO = 3'd0,  // +0
    B_PM   = 3'd1,  // +M
    B_P2M  = 3'd2,  // +2M
    B_NM   = 3'd3,  // -M
    B_N2M  = 3'd4   // -2M
  } booth_op_e;

  function automatic string booth_op_name(booth_op_e op);
    case (op)
      B_ZERO:  return "0";
      B_PM:    return "+M";
      B_P2M:   return "+2M";
      B_NM:    return "-M";
      B_N2M:   return "-2M";
      default: return "?";
    endcase
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// ---------------------------------------------------------------------------
// booth_recoder
//   Purely combinational radix-4 Booth recoder. Looks at one overlapping
//   bit group {q[i+1], q[i], q[i-1]} and selects the partial-product term.
//
// Ports
//   group  in   3  {P[1], P[0], q_-1} of the current multiplier window
//   op     out  booth_op_e  selected term (0, +M, +2M, -M, -2M)
// ---------------------------------------------------------------------------
module booth_recoder
  import mul_div_pkg::*;
(
  input  logic [2:0] group,
  output booth_op_e  op
);

  always_comb begin
    op = B_ZERO;
    case (group)
      3'b000, 3'b111: op = B_ZERO;  // run of equal bits: nothing to add
      3'b001, 3'b010: op = B_PM;
      3'b011:         op = B_P2M;   // end of a run of ones
      3'b100:         op = B_N2M;   // start of a run of ones
      3'b101, 3'b110: op = B_NM;
      default:        op = B_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// ---------------------------------------------------------------------------
// booth_mul_seq
//   Sequential signed WIDTH x WIDTH multiplier, radix-4 Booth recoding,
//   WIDTH/2 iterations. Companion of the non-restoring divider: the
//   2*WIDTH-bit product is returned as a HI/LO pair like the divider's Z.
//
// Ports
//   clk         in   1      system clock, rising edge
//   resetn      in   1      synchronous active-low reset
//   start       in   1      request; operands sampled when accepted
//                           (in IDLE or in the single DONE cycle)
//   M           in   WIDTH  multiplicand, two's complement
//   Q           in   WIDTH  multiplier, two's complement
//   busy        out  1      high while iterating
//   done        out  1      one-cycle pulse, product valid
//   product_hi  out  WIDTH  product[2*WIDTH-1:WIDTH]
//   product_lo  out  WIDTH  product[WIDTH-1:0]
//
// Timing: start accepted at edge 0, done high in the cycle after edge ITER,
// busy high for exactly ITER cycles in between. start while busy is ignored.
// WIDTH must be even and at least 4.
// ---------------------------------------------------------------------------
module booth_mul_seq
  import mul_div_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
)(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int ITER = WIDTH / 2;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

  // Accumulator and multiplicand carry two extra bits: the largest term is
  // 2*|M| with M = -2^(WIDTH-1), which needs WIDTH+1 magnitude bits plus sign.
  mul_state_e       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH+1:0] m_reg;
  logic [WIDTH+1:0] a_reg;
  logic [WIDTH-1:0] p_reg;
  logic             qm1_reg;

  booth_op_e        op;
  logic [WIDTH+1:0] term;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] a_next;
  logic [WIDTH-1:0] p_next;
  logic             qm1_next;

  booth_recoder u_recoder (
    .group ({p_reg[1:0], qm1_reg}),
    .op    (op)
  );

  // One Booth step: add the selected term, then shift {A,P,q_-1} right by
  // two arithmetically. The two bits leaving A enter the top of P, and
  // P[1] becomes the new q_-1 for the next overlapping group.
  always_comb begin
    term = '0;
    case (op)
      B_ZERO: term = '0;
      B_PM:   term = m_reg;
      B_P2M:  term = m_reg << 1;
      B_NM:   term = -m_reg;
      B_N2M:  term = -(m_reg << 1);
      default: term = '0;
    endcase
    sum      = a_reg + term;
    a_next   = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
    p_next   = {sum[1:0], p_reg[WIDTH-1:2]};
    qm1_next = p_reg[1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      m_reg      <= '0;
      a_reg      <= '0;
      p_reg      <= '0;
      qm1_reg    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      case (state_reg)
        // DONE accepts start exactly like IDLE so operations can run
        // back to back; the product registers are untouched here.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m_reg     <= {{2{M[WIDTH-1]}}, M};
            a_reg     <= '0;
            p_reg     <= Q;
            qm1_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end

        RUN: begin
          a_reg   <= a_next;
          p_reg   <= p_next;
          qm1_reg <= qm1_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            // After the last step A holds the high word (its top two bits
            // are pure sign) and P holds the low word.
            product_hi <= a_next[WIDTH-1:0];
            product_lo <= p_next;
            busy       <= 1'b0;
            done       <= 1'b1;
            state_reg  <= DONE;
          end
        end

        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_seq
//   Self-checking bench for booth_mul_seq (WIDTH=32): directed vector table,
//   multi-cycle corner sequences, and random operands checked against a
//   plain signed-multiply reference.
// ---------------------------------------------------------------------------
module tb_booth_mul_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [31:0] M;
  logic [31:0] Q;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;

  int compared   = 0;
  int mismatched = 0;

  booth_mul_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .M          (M),
    .Q          (Q),
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] m;
    logic [31:0] q;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[6];

  // Reference: exact signed product using 64-bit integer arithmetic.
  function automatic logic [63:0] ref_mul(logic [31:0] m, logic [31:0] q);
    longint a;
    longint b;
    a = longint'($signed(m));
    b = longint'($signed(q));
    return 64'(a * b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for done. Operands are
  // scrambled right after acceptance; start is re-pulsed on the listed
  // busy cycles to show it is ignored.
  task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                        input int poke1, input int poke2,
                        output logic [63:0] prod, output int cycles,
                        output int busy_cyc, output logic busy_at_done);
    @(negedge clk);
    M = m; Q = q; start = 1'b1;
    @(negedge clk);
    start = 1'b0; M = $urandom; Q = $urandom;
    cycles = 0;
    busy_cyc = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_cyc++;
      cycles++;
      if (cycles == poke1 || cycles == poke2) begin
        start = 1'b1; M = $urandom; Q = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    busy_at_done = busy;
    prod = {product_hi, product_lo};
  endtask

  task automatic check_op(input string name, input logic [31:0] m, input logic [31:0] q,
                          input logic [63:0] exp, input int poke1, input int poke2,
                          input bit timing);
    logic [63:0] prod;
    int cycles;
    int busy_cyc;
    logic bad;
    run_op(m, q, poke1, poke2, prod, cycles, busy_cyc, bad);
    $display("op %s: M=%h Q=%h -> %h (expect %h) busy=%0d", name, m, q, prod, exp, busy_cyc);
    chk(name, prod, exp);
    if (timing) begin
      chk({name, "/done_cycle"}, 64'(cycles), 64'd16);
      chk({name, "/busy_cycles"}, 64'(busy_cyc), 64'd16);
      chk({name, "/busy_at_done"}, {63'd0, bad}, 64'd0);
      @(negedge clk);
      chk({name, "/done_pulse"}, {63'd0, done}, 64'd0);
      chk({name, "/hold"}, {product_hi, product_lo}, exp);
    end
  endtask

  initial begin
    logic [63:0] p1;
    logic [63:0] p2;
    int cyc;

    vecs[0] = '{"38x6",      32'd38,        32'd6,         32'h00000000, 32'h000000E4};
    vecs[1] = '{"-7x5",      32'hFFFFFFF9,  32'd5,         32'hFFFFFFFF, 32'hFFFFFFDD};
    vecs[2] = '{"5x-7",      32'd5,         32'hFFFFFFF9,  32'hFFFFFFFF, 32'hFFFFFFDD};
    vecs[3] = '{"max*max",   32'h7FFFFFFF,  32'h7FFFFFFF,  32'h3FFFFFFF, 32'h00000001};
    vecs[4] = '{"min*min",   32'h80000000,  32'h80000000,  32'h40000000, 32'h00000000};
    vecs[5] = '{"min*-1",    32'h80000000,  32'hFFFFFFFF,  32'h00000000, 32'h80000000};

    resetn = 1'b0; start = 1'b1; M = 32'd3; Q = 32'd4;
    repeat (3) @(negedge clk);
    // start was high throughout reset: reset must win.
    chk("reset/busy", {63'd0, busy}, 64'd0);
    chk("reset/done", {63'd0, done}, 64'd0);
    chk("reset/product", {product_hi, product_lo}, 64'd0);
    start = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    chk("idle/busy", {63'd0, busy}, 64'd0);

    foreach (vecs[i])
      check_op(vecs[i].name, vecs[i].m, vecs[i].q, {vecs[i].hi, vecs[i].lo}, -1, -1, 1'b1);

    // start re-pulsed at busy cycles 3 and 10 with other operands.
    check_op("ignore_start", 32'd38, 32'd6, 64'h00000000_000000E4, 3, 10, 1'b1);

    // Reset in the middle of a run.
    @(negedge clk);
    M = 32'h12345; Q = 32'h6789; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midreset/busy", {63'd0, busy}, 64'd0);
    chk("midreset/done", {63'd0, done}, 64'd0);
    chk("midreset/product", {product_hi, product_lo}, 64'd0);
    check_op("after_reset", 32'd100, 32'd25, 64'h00000000_000009C4, -1, -1, 1'b1);

    // Back to back: start held high through DONE.
    @(negedge clk);
    M = 32'd1234; Q = 32'hFFFFFF00; start = 1'b1;
    @(negedge clk);
    M = 32'hFFFF0003; Q = 32'd77;  // operands for the second operation
    cyc = 0;
    while (!done && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    p1 = ref_mul(32'd1234, 32'hFFFFFF00);
    chk("b2b/first_cycle", 64'(cyc), 64'd16);
    chk("b2b/first", {product_hi, product_lo}, p1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b/accepted_busy", {63'd0, busy}, 64'd1);
    chk("b2b/done_pulse", {63'd0, done}, 64'd0);
    cyc = 1;
    while (!done && cyc < 40) begin
      if ({product_hi, product_lo} !== p1) begin
        chk("b2b/first_holds", {product_hi, product_lo}, p1);
        break;
      end
      cyc++;
      @(negedge clk);
    end
    p2 = ref_mul(32'hFFFF0003, 32'd77);
    $display("op b2b: first=%h second=%h spacing=%0d", p1, {product_hi, product_lo}, cyc);
    chk("b2b/spacing", 64'(cyc), 64'd17);
    chk("b2b/second", {product_hi, product_lo}, p2);

    // Random operands against the reference, with extremes mixed in.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] rm;
      logic [31:0] rq;
      rm = $urandom;
      rq = $urandom;
      case ($urandom_range(0, 5))
        0: rm = 32'h80000000;
        1: rq = 32'h80000000;
        2: rq = 32'h7FFFFFFF;
        3: rm = 32'hFFFFFFFF;
        default: ;
      endcase
      check_op($sformatf("rand%0d", n), rm, rq, ref_mul(rm, rq), -1, -1, (n % 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
